// File: rtl/shared_pipe_arbiter_pkg.sv
// Shared helpers for the DQN datapath arbiter: ID sizing and the round-robin search.
package dqn_arb_pkg;

    localparam int MAX_REQ = 32;
    localparam int MAX_IW  = 5;

    // ID width that stays at least one bit wide for two requesters.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // One-hot of the first set bit of elig, searching from ptr upward and wrapping at n.
    function automatic logic [MAX_REQ-1:0] rr_pick(
        input logic [MAX_REQ-1:0] elig,
        input int                 n,
        input int                 ptr
    );
        logic [MAX_REQ-1:0] oh;
        logic               found;
        int                 idx;
        oh    = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            if (k < n && !found) begin
                idx = ptr + k;
                if (idx >= n) idx = idx - n;
                if (elig[idx[MAX_IW-1:0]]) begin
                    oh[idx[MAX_IW-1:0]] = 1'b1;
                    found               = 1'b1;
                end
            end
        end
        return oh;
    endfunction

endpackage

// File: rtl/shared_pipe_arbiter_tag_delay.sv
// Fixed-depth shift register carrying {valid, id} tags alongside the shared unit.
module tag_delay #(
    parameter int WIDTH   = 1,
    parameter int LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [LATENCY-1:0][WIDTH-1:0] stage_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < LATENCY; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign q_o = stage_q[LATENCY-1];

endmodule

// File: rtl/shared_pipe_arbiter.sv
// Round-robin arbiter feeding one fixed-latency pipelined unit and routing results back by tag.
module shared_pipe_arbiter
    import dqn_arb_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int NUM_REQ    = 4,
    parameter  int LATENCY    = 2,
    localparam int ID_W       = clog2_min1(NUM_REQ),
    localparam int CW         = $clog2(LATENCY + 2)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_mask,
    output logic [NUM_REQ-1:0]            gnt,
    output logic                          issue_valid,
    output logic [DATA_WIDTH-1:0]         issue_data,
    input  logic [DATA_WIDTH-1:0]         res_data,
    output logic [NUM_REQ-1:0]            resp_valid,
    output logic [DATA_WIDTH-1:0]         resp_data,
    output logic [CW-1:0]                 in_flight,
    output logic                          idle
);

    logic [NUM_REQ-1:0]    eligible;
    logic [ID_W-1:0]       ptr_q, ptr_d;
    logic [ID_W-1:0]       gnt_idx;
    logic                  gnt_any;
    logic [DATA_WIDTH-1:0] gnt_data;

    logic                  issue_valid_q;
    logic [DATA_WIDTH-1:0] issue_data_q;
    logic [ID_W-1:0]       issue_id_q;

    logic [ID_W:0]         tag_ret;
    logic                  ret_valid;
    logic [ID_W-1:0]       ret_id;

    logic [NUM_REQ-1:0]    resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0] resp_data_q;
    logic [CW-1:0]         in_flight_q, in_flight_d;

    assign eligible = req & req_mask;
    assign gnt      = NUM_REQ'(rr_pick(MAX_REQ'(eligible), NUM_REQ, int'(ptr_q)));
    assign gnt_any  = |gnt;

    always_comb begin
        gnt_idx  = '0;
        gnt_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                gnt_idx  = ID_W'(i);
                gnt_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign ptr_d = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

    // issue_data keeps its last operand when nothing is granted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q         <= '0;
            issue_valid_q <= 1'b0;
            issue_data_q  <= '0;
            issue_id_q    <= '0;
        end else begin
            issue_valid_q <= gnt_any;
            if (gnt_any) begin
                ptr_q        <= ptr_d;
                issue_data_q <= gnt_data;
                issue_id_q   <= gnt_idx;
            end
        end
    end

    // Output of the last stage lines up with res_data for the matching issue.
    tag_delay #(
        .WIDTH   (1 + ID_W),
        .LATENCY (LATENCY)
    ) u_tag_delay (
        .clk (clk),
        .rst (rst),
        .d_i ({issue_valid_q, issue_id_q}),
        .q_o (tag_ret)
    );

    assign ret_valid = tag_ret[ID_W];
    assign ret_id    = tag_ret[ID_W-1:0];

    always_comb begin
        resp_valid_d = '0;
        if (ret_valid) resp_valid_d[ret_id] = 1'b1;
    end

    // Counted from issue to registered response, so a steady stream sits at LATENCY+1.
    assign in_flight_d = in_flight_q + CW'(issue_valid_q) - CW'(|resp_valid_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid_q <= '0;
            resp_data_q  <= '0;
            in_flight_q  <= '0;
        end else begin
            resp_valid_q <= resp_valid_d;
            if (ret_valid) resp_data_q <= res_data;
            in_flight_q  <= in_flight_d;
        end
    end

    assign issue_valid = issue_valid_q;
    assign issue_data  = issue_data_q;
    assign resp_valid  = resp_valid_q;
    assign resp_data   = resp_data_q;
    assign in_flight   = in_flight_q;
    assign idle        = (in_flight_q == '0) && !(|eligible);

endmodule

// File: tb/tb_shared_pipe_arbiter.sv
// Directed bench for shared_pipe_arbiter with a data+1 unit model of depth LATENCY.
module tb_shared_pipe_arbiter;

    localparam int DW = 32;
    localparam int NR = 4;
    localparam int L  = 2;
    localparam int CW = $clog2(L + 2);

    logic             clk = 1'b0;
    logic             rst;
    logic [NR-1:0]    req;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]    req_mask;
    logic [NR-1:0]    gnt;
    logic             issue_valid;
    logic [DW-1:0]    issue_data;
    logic [DW-1:0]    res_data;
    logic [NR-1:0]    resp_valid;
    logic [DW-1:0]    resp_data;
    logic [CW-1:0]    in_flight;
    logic             idle;

    int n_chk  = 0;
    int n_pass = 0;

    shared_pipe_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .LATENCY(L)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_data    (req_data),
        .req_mask    (req_mask),
        .gnt         (gnt),
        .issue_valid (issue_valid),
        .issue_data  (issue_data),
        .res_data    (res_data),
        .resp_valid  (resp_valid),
        .resp_data   (resp_data),
        .in_flight   (in_flight),
        .idle        (idle)
    );

    always #5 clk = ~clk;

    // Shared unit: result = operand + 1, L cycles after issue_valid, independent of rst.
    logic [DW-1:0] u0, u1;
    always @(posedge clk) begin
        u0 <= issue_data + 32'd1;
        u1 <= u0;
    end
    assign res_data = u1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int i, input logic [DW-1:0] v);
        req_data[i*DW +: DW] = v;
    endtask

    initial begin
        rst      = 1'b1;
        req      = '0;
        req_data = '0;
        req_mask = '1;

        // Reset state
        next();
        @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_issue_valid", 32'(issue_valid), 32'h0);
        chk("rst_issue_data", issue_data, 32'h0);
        chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("rst_resp_data", resp_data, 32'h0);
        chk("rst_in_flight", 32'(in_flight), 32'h0);
        chk("rst_idle", 32'(idle), 32'h1);
        next();
        rst = 1'b0;

        // All four requesting: rotating grants, responses LATENCY+2 cycles later in order
        for (int i = 0; i < NR; i++) set_data(i, 32'h100 + 32'(i));
        for (int k = 0; k < 13; k++) begin
            if (k > 0) next();
            req = (k < 8) ? 4'b1111 : 4'b0000;
            @(negedge clk);
            if (k < 13) begin
                chk($sformatf("rr_gnt_%0d", k), 32'(gnt), (k < 8) ? (32'h1 << (k % 4)) : 32'h0);
                chk($sformatf("rr_resp_valid_%0d", k), 32'(resp_valid),
                    (k >= 4 && k < 12) ? (32'h1 << ((k - 4) % 4)) : 32'h0);
            end
            if (k >= 4 && k < 12)
                chk($sformatf("rr_resp_data_%0d", k), resp_data, 32'h101 + 32'((k - 4) % 4));
            if (k == 7)  chk("rr_in_flight_full", 32'(in_flight), 32'(L + 1));
            if (k == 11) chk("rr_in_flight_tail", 32'(in_flight), 32'h1);
            if (k == 12) begin
                chk("rr_in_flight_drained", 32'(in_flight), 32'h0);
                chk("rr_idle_drained", 32'(idle), 32'h1);
            end
        end

        // Sparse request 0101 from ptr 0; unit adds one
        next();
        set_data(0, 32'hA);
        set_data(2, 32'hB);
        req = 4'b0101;
        @(negedge clk);
        chk("sp_gnt0", 32'(gnt), 32'b0001);
        next();
        req = 4'b0100;
        @(negedge clk);
        chk("sp_gnt2", 32'(gnt), 32'b0100);
        chk("sp_issue_data0", issue_data, 32'hA);
        next();
        req = 4'b0000;
        @(negedge clk);
        chk("sp_issue_data2", issue_data, 32'hB);
        next();
        @(negedge clk);
        chk("sp_no_resp_yet", 32'(resp_valid), 32'h0);
        next();
        @(negedge clk);
        chk("sp_resp_valid0", 32'(resp_valid), 32'b0001);
        chk("sp_resp_data0", resp_data, 32'hB);
        next();
        @(negedge clk);
        chk("sp_resp_valid2", 32'(resp_valid), 32'b0100);
        chk("sp_resp_data2", resp_data, 32'hC);
        next();

        // Masked requester ignored until its mask rises, then granted that same cycle
        set_data(3, 32'h33);
        req      = 4'b1000;
        req_mask = 4'b0111;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) next();
            @(negedge clk);
            chk($sformatf("mask_gnt_%0d", k), 32'(gnt), 32'h0);
            chk($sformatf("mask_idle_%0d", k), 32'(idle), 32'h1);
        end
        next();
        req_mask = 4'b1111;
        @(negedge clk);
        chk("mask_rise_gnt", 32'(gnt), 32'b1000);
        chk("mask_rise_idle", 32'(idle), 32'h0);
        next();
        req = '0;
        for (int k = 0; k < 5; k++) next();

        // Single requester streaming: full throughput, in_flight plateau and drain
        set_data(1, 32'h55);
        for (int k = 0; k < 11; k++) begin
            if (k > 0) next();
            req = (k < 6) ? 4'b0010 : 4'b0000;
            @(negedge clk);
            if (k < 6) chk($sformatf("one_gnt_%0d", k), 32'(gnt), 32'b0010);
            if (k >= 4 && k < 10) begin
                chk($sformatf("one_resp_valid_%0d", k), 32'(resp_valid), 32'b0010);
                chk($sformatf("one_resp_data_%0d", k), resp_data, 32'h56);
            end
            if (k == 5)  chk("one_in_flight_full", 32'(in_flight), 32'(L + 1));
            if (k == 9)  chk("one_in_flight_tail", 32'(in_flight), 32'h1);
            if (k == 10) chk("one_in_flight_zero", 32'(in_flight), 32'h0);
        end
        next();

        // Reset with two ops in flight: both discarded, pointer back to 0
        set_data(0, 32'h70);
        set_data(1, 32'h71);
        set_data(2, 32'h72);
        req = 4'b0011;
        @(negedge clk);
        chk("mr_gnt0", 32'(gnt), 32'b0001);
        next();
        req = 4'b0010;
        @(negedge clk);
        chk("mr_gnt1", 32'(gnt), 32'b0010);
        next();
        req = 4'b0000;
        next();
        chk("mr_in_flight_two", 32'(in_flight), 32'h2);
        rst = 1'b1;
        @(negedge clk);
        chk("mr_in_flight_cleared", 32'(in_flight), 32'h0);
        chk("mr_issue_valid", 32'(issue_valid), 32'h0);
        chk("mr_idle", 32'(idle), 32'h1);
        for (int k = 0; k < 5; k++) begin
            next();
            if (k == 1) rst = 1'b0;
            @(negedge clk);
            chk($sformatf("mr_no_resp_%0d", k), 32'(resp_valid), 32'h0);
        end
        next();
        req = 4'b0110;
        @(negedge clk);
        chk("mr_ptr_zero_gnt", 32'(gnt), 32'b0010);
        next();
        req = '0;
        next();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
